// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the multi-step, multi-form LFSR generator.
package lfsr_pkg;

   typedef enum logic {GALOIS, FIBONACCI} lfsr_mode_t;
   typedef enum logic [1:0] {IDLE, RUN, LOCKUP} lfsr_state_t;

   localparam int LFSR_MAX_W = 32;

   // Low 'len' bits set; callers truncate to their own register width.
   function automatic logic [LFSR_MAX_W-1:0] len_mask(input logic [5:0] len);
      logic [LFSR_MAX_W:0] m;
      m = (33'd1 << len) - 33'd1;
      return m[LFSR_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step in either Galois or Fibonacci form.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] state_i,
   input  logic [W-1:0] poly_i,
   input  logic [W-1:0] mask_i,
   input  logic         mode_i,
   output logic [W-1:0] next_o,
   output logic         bit_o
);

   logic [W-1:0] shr;
   logic [W-1:0] top;

   assign bit_o = state_i[0];
   assign shr   = state_i >> 1;
   // Highest set bit of the mask is bit L-1, where Fibonacci feedback enters.
   assign top   = mask_i & ~(mask_i >> 1);

   always_comb begin
      if (lfsr_mode_t'(mode_i) == FIBONACCI)
         next_o = shr | ((^(state_i & poly_i)) ? top : '0);
      else
         next_o = shr ^ (bit_o ? poly_i : '0);
   end

endmodule

// File: rtl/lfsr_multi.sv
// Runtime-length Galois/Fibonacci LFSR with STEPS shifts per clock,
// lock-up detection and hardware period measurement.
module lfsr_multi
   import lfsr_pkg::*;
#(
   parameter int  MAX_LEN = 8,
   parameter int  STEPS   = 1,
   parameter int  CNT_W   = MAX_LEN + 1,
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               CLK_I,
   input  logic               RST_N_I,
   input  logic               EN_I,
   input  logic               LOAD_I,
   input  logic               MODE_I,
   input  logic [LW-1:0]      LEN_I,
   input  logic [MAX_LEN-1:0] SEED_I,
   input  logic [MAX_LEN-1:0] POLY_I,
   output logic [MAX_LEN-1:0] DATA_O,
   output logic [STEPS-1:0]   BIT_O,
   output logic               VALID_O,
   output logic               WRAP_O,
   output logic [CNT_W-1:0]   PERIOD_O,
   output logic               PERIOD_VLD_O,
   output logic               LOCKUP_O
);

   localparam int JW = 4;

   lfsr_state_t        fsm_q, fsm_d;
   lfsr_mode_t         mode_q, mode_d;
   logic [MAX_LEN-1:0] state_q, state_d;
   logic [MAX_LEN-1:0] seed_q, seed_d;
   logic [MAX_LEN-1:0] poly_q, poly_d;
   logic [MAX_LEN-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               pvld_q, pvld_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;
   logic [STEPS-1:0]   bit_q, bit_d;

   logic [LW-1:0]            len_c;
   logic [MAX_LEN-1:0]       mask_new;
   logic [MAX_LEN-1:0]       seed_new;
   logic [STEPS:0][MAX_LEN-1:0] chain_s;
   logic [STEPS-1:0]         step_bit;
   logic [JW-1:0]            wrap_j;
   logic [CNT_W:0]           per_sum;
   logic [CNT_W:0]           cnt_sum;

   always_comb begin
      len_c = LEN_I;
      if (LEN_I < LW'(2) || LEN_I > LW'(MAX_LEN))
         len_c = LW'(MAX_LEN);
   end

   assign mask_new = MAX_LEN'(len_mask(6'(len_c)));
   assign seed_new = SEED_I & mask_new;

   assign chain_s[0] = state_q;

   for (genvar k = 0; k < STEPS; k++) begin : g_step
      lfsr_step #(.W(MAX_LEN)) u_step (
         .state_i (chain_s[k]),
         .poly_i  (poly_q),
         .mask_i  (mask_q),
         .mode_i  (mode_q),
         .next_o  (chain_s[k+1]),
         .bit_o   (step_bit[k])
      );
   end

   // Earliest sub-step that lands back on the seed; 0 means none this clock.
   always_comb begin
      wrap_j = '0;
      for (int k = STEPS; k >= 1; k--)
         if (chain_s[k] == seed_q)
            wrap_j = JW'(k);
   end

   // Top carry bit set means the sum left the counter range (saturated).
   assign per_sum = {1'b0, cnt_q} + (CNT_W+1)'(wrap_j);
   assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(STEPS);

   always_comb begin
      fsm_d    = fsm_q;
      mode_d   = mode_q;
      state_d  = state_q;
      seed_d   = seed_q;
      poly_d   = poly_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      pvld_d   = pvld_q;
      bit_d    = bit_q;
      valid_d  = 1'b0;
      wrap_d   = 1'b0;
      if (LOAD_I) begin
         mode_d  = lfsr_mode_t'(MODE_I);
         mask_d  = mask_new;
         seed_d  = seed_new;
         poly_d  = POLY_I & mask_new;
         state_d = seed_new;
         cnt_d   = '0;
         pvld_d  = 1'b0;
         fsm_d   = (seed_new == '0) ? LOCKUP : RUN;
      end else if (fsm_q == RUN && EN_I) begin
         state_d = chain_s[STEPS];
         bit_d   = step_bit;
         valid_d = 1'b1;
         if (wrap_j != '0) begin
            wrap_d = 1'b1;
            cnt_d  = CNT_W'(STEPS) - CNT_W'(wrap_j);
            if (!per_sum[CNT_W]) begin
               period_d = per_sum[CNT_W-1:0];
               pvld_d   = 1'b1;
            end
         end else begin
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
         end
         if (chain_s[STEPS] == '0)
            fsm_d = LOCKUP;
      end
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         fsm_q    <= IDLE;
         mode_q   <= GALOIS;
         state_q  <= '0;
         seed_q   <= '0;
         poly_q   <= '0;
         mask_q   <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         pvld_q   <= 1'b0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
         bit_q    <= '0;
      end else begin
         fsm_q    <= fsm_d;
         mode_q   <= mode_d;
         state_q  <= state_d;
         seed_q   <= seed_d;
         poly_q   <= poly_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pvld_q   <= pvld_d;
         valid_q  <= valid_d;
         wrap_q   <= wrap_d;
         bit_q    <= bit_d;
      end
   end

   assign DATA_O       = state_q;
   assign BIT_O        = bit_q;
   assign VALID_O      = valid_q;
   assign WRAP_O       = wrap_q;
   assign PERIOD_O     = period_q;
   assign PERIOD_VLD_O = pvld_q;
   assign LOCKUP_O     = (fsm_q == LOCKUP);

endmodule

// File: tb/tb_lfsr_multi.sv
// Bench for lfsr_multi: STEPS=1 and STEPS=2 instances driven in parallel,
// checked every cycle against an arithmetic reference model.
module tb_lfsr_multi;

   localparam int ML   = 8;
   localparam int CW   = ML + 1;
   localparam int ALL1 = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, load = 1'b0, mode = 1'b0;
   logic [3:0] len = '0;
   logic [7:0] seed = '0, poly = '0;

   always #5 clk = ~clk;

   logic [7:0]    data1, data2;
   logic [0:0]    bit1;
   logic [1:0]    bit2;
   logic          valid1, valid2, wrap1, wrap2, pvld1, pvld2, lock1, lock2;
   logic [CW-1:0] per1, per2;

   lfsr_multi #(.MAX_LEN(ML), .STEPS(1)) u_dut1 (
      .CLK_I(clk), .RST_N_I(rst_n), .EN_I(en), .LOAD_I(load), .MODE_I(mode),
      .LEN_I(len), .SEED_I(seed), .POLY_I(poly), .DATA_O(data1), .BIT_O(bit1),
      .VALID_O(valid1), .WRAP_O(wrap1), .PERIOD_O(per1), .PERIOD_VLD_O(pvld1),
      .LOCKUP_O(lock1));

   lfsr_multi #(.MAX_LEN(ML), .STEPS(2)) u_dut2 (
      .CLK_I(clk), .RST_N_I(rst_n), .EN_I(en), .LOAD_I(load), .MODE_I(mode),
      .LEN_I(len), .SEED_I(seed), .POLY_I(poly), .DATA_O(data2), .BIT_O(bit2),
      .VALID_O(valid2), .WRAP_O(wrap2), .PERIOD_O(per2), .PERIOD_VLD_O(pvld2),
      .LOCKUP_O(lock2));

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: [0] tracks the 1-step instance, [1] the 2-step one.
   logic [7:0] m_state[2], m_seed[2], m_poly[2], m_bits[2];
   logic       m_fib[2], m_loaded[2], m_locked[2], m_valid[2], m_wrap[2], m_pvld[2];
   int         m_L[2], m_period[2], m_abs[2], m_ref[2];

   function automatic logic [8:0] mstep(input logic [7:0] s, input logic [7:0] p,
                                        input int L, input logic fib);
      int sv, b, n;
      sv = int'(s);
      b  = sv % 2;
      n  = sv / 2;
      if (!fib) begin
         if (b == 1) n = n ^ int'(p);
      end else if (($countones(s & p) % 2) == 1) begin
         n = n + (1 << (L - 1));
      end
      return {b[0], n[7:0]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_state[i] = 0; m_seed[i] = 0; m_poly[i] = 0; m_bits[i] = 0;
            m_fib[i] = 0; m_loaded[i] = 0; m_locked[i] = 0; m_valid[i] = 0;
            m_wrap[i] = 0; m_pvld[i] = 0; m_L[i] = 0; m_period[i] = 0;
            m_abs[i] = 0; m_ref[i] = 0;
         end else if (load) begin
            m_L[i]      = (int'(len) < 2 || int'(len) > ML) ? ML : int'(len);
            m_seed[i]   = seed & 8'((1 << m_L[i]) - 1);
            m_poly[i]   = poly & 8'((1 << m_L[i]) - 1);
            m_fib[i]    = mode;
            m_state[i]  = m_seed[i];
            m_loaded[i] = 1;
            m_locked[i] = (m_seed[i] == 0);
            m_valid[i]  = 0;
            m_wrap[i]   = 0;
            m_pvld[i]   = 0;
            m_abs[i]    = 0;
            m_ref[i]    = 0;
         end else if (m_loaded[i] && !m_locked[i] && en) begin
            int first, since;
            logic [8:0] r;
            first = 0;
            for (int j = 1; j <= i + 1; j++) begin
               r = mstep(m_state[i], m_poly[i], m_L[i], m_fib[i]);
               m_bits[i][j-1] = r[8];
               m_state[i] = r[7:0];
               if (first == 0 && m_state[i] == m_seed[i]) first = j;
            end
            m_valid[i] = 1;
            m_wrap[i]  = (first != 0);
            if (first != 0) begin
               since = m_abs[i] - m_ref[i];
               if (since > ALL1) since = ALL1;
               if (since + first <= ALL1) begin
                  m_period[i] = m_abs[i] + first - m_ref[i];
                  m_pvld[i]   = 1;
               end
               m_ref[i] = m_abs[i] + first;
            end
            m_abs[i] += i + 1;
            if (m_state[i] == 0) m_locked[i] = 1;
         end else begin
            m_valid[i] = 0;
            m_wrap[i]  = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("d1.data",   32'(data1),  32'(m_state[0]));
      chk("d1.bit",    32'(bit1),   32'(m_bits[0]));
      chk("d1.valid",  32'(valid1), 32'(m_valid[0]));
      chk("d1.wrap",   32'(wrap1),  32'(m_wrap[0]));
      chk("d1.period", 32'(per1),   32'(m_period[0]));
      chk("d1.pvld",   32'(pvld1),  32'(m_pvld[0]));
      chk("d1.lockup", 32'(lock1),  32'(m_loaded[0] & m_locked[0]));
      chk("d2.data",   32'(data2),  32'(m_state[1]));
      chk("d2.bit",    32'(bit2),   32'(m_bits[1]));
      chk("d2.valid",  32'(valid2), 32'(m_valid[1]));
      chk("d2.wrap",   32'(wrap2),  32'(m_wrap[1]));
      chk("d2.period", 32'(per2),   32'(m_period[1]));
      chk("d2.pvld",   32'(pvld2),  32'(m_pvld[1]));
      chk("d2.lockup", 32'(lock2),  32'(m_loaded[1] & m_locked[1]));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_load(input logic md, input logic [3:0] ln,
                          input logic [7:0] sd, input logic [7:0] pl);
      load = 1'b1; mode = md; len = ln; seed = sd; poly = pl;
      tick();
      load = 1'b0;
   endtask

   initial begin
      tick(); tick();
      chk("reset.data", 32'(data1), 32'h0);
      chk("reset.lock", 32'(lock1), 32'h0);
      rst_n = 1'b1;
      en = 1'b1;
      tick();
      chk("idle.valid", 32'(valid1), 32'h0);
      en = 1'b0;

      // Galois, L=4, poly 1100, seed 0001
      do_load(1'b0, 4'd4, 8'h01, 8'h0C);
      chk("g.load.data", 32'(data1), 32'h01);
      en = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 1) begin
            chk("g.d1.s1", 32'(data1), 32'h0C);
            chk("g.d2.data", 32'(data2), 32'h06);
            chk("g.d2.bit", 32'(bit2), 32'h1);
            chk("g.d2.valid", 32'(valid2), 32'h1);
         end
         if (k == 2) chk("g.d1.s2", 32'(data1), 32'h06);
         if (k == 3) chk("g.d1.s3", 32'(data1), 32'h03);
         if (k == 4) chk("g.d1.s4", 32'(data1), 32'h0D);
         if (k == 8) begin
            chk("g.d2.wrap", 32'(wrap2), 32'h1);
            chk("g.d2.period", 32'(per2), 32'd15);
         end
         if (k == 15) begin
            chk("g.d1.wrap", 32'(wrap1), 32'h1);
            chk("g.d1.period", 32'(per1), 32'd15);
            chk("g.d1.pvld", 32'(pvld1), 32'h1);
         end
      end
      en = 1'b0;

      // Fibonacci, L=4, poly 0011, seed 0001
      do_load(1'b1, 4'd4, 8'h01, 8'h03);
      en = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 1) chk("f.s1", 32'(data1), 32'h08);
         if (k == 2) chk("f.s2", 32'(data1), 32'h04);
         if (k == 3) chk("f.s3", 32'(data1), 32'h02);
         if (k == 4) chk("f.s4", 32'(data1), 32'h09);
         if (k == 5) chk("f.s5", 32'(data1), 32'h0C);
         if (k == 15) chk("f.period", 32'(per1), 32'd15);
      end

      // zero seed locks up until the next load
      do_load(1'b0, 4'd4, 8'h00, 8'h0C);
      chk("lk.lockup", 32'(lock1), 32'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("lk.valid", 32'(valid1), 32'h0);
         chk("lk.data", 32'(data1), 32'h0);
      end
      do_load(1'b0, 4'd4, 8'h01, 8'h0C);
      chk("lk.exit", 32'(lock1), 32'h0);
      tick();
      chk("lk.resume", 32'(data1), 32'h0C);

      // load wins over a simultaneous enable
      for (int k = 0; k < 16; k++) tick();
      chk("ld.pvld.before", 32'(pvld1), 32'h1);
      load = 1'b1; seed = 8'h05;
      tick();
      load = 1'b0;
      chk("ld.data", 32'(data1), 32'h05);
      chk("ld.valid", 32'(valid1), 32'h0);
      chk("ld.pvld", 32'(pvld1), 32'h0);

      // asynchronous reset mid-run
      for (int k = 0; k < 3; k++) tick();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.data", 32'(data1), 32'h0);
      chk("ar.d2data", 32'(data2), 32'h0);
      chk("ar.period", 32'(per1), 32'h0);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ar.idle.valid", 32'(valid1), 32'h0);
      end

      // randomized traffic, including out-of-range lengths and degenerate polys
      do_load(1'b0, 4'd5, 8'h13, 8'h14);
      for (int c = 0; c < 600; c++) begin
         load = ($urandom_range(0, 24) == 0);
         if (load) begin
            mode = 1'($urandom_range(0, 1));
            len  = 4'($urandom_range(0, 15));
            seed = 8'($urandom);
            poly = 8'($urandom);
         end
         en = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lfsr_multi.md
Name: lfsr_multi

Overview:
Parametrised successor to the fixed-length Galois LFSR generator.
- Runtime-selectable register length.
- Runtime-selectable form: Galois or Fibonacci, chosen at load.
- Multiple shift steps per clock.
- Detects the all-zero lock-up state and measures the sequence period in hardware.
- Used as a PRBS/scrambler source and as a self-checking polynomial characteriser in the ASIC_design labs.

Parameters:
MAX_LEN, 8, maximum register length in bits (2..32).
STEPS, 1, LFSR steps applied per enabled clock (1..8).
CNT_W, MAX_LEN+1, width of the period counter.

Ports:
CLK_I  in  1  clock, rising edge.
RST_N_I  in  1  reset, asynchronous assert, active-low.
EN_I  in  1  advance by STEPS when in RUN.
LOAD_I  in  1  load SEED_I; latch POLY_I, LEN_I and MODE_I.
MODE_I  in  1  0 = Galois, 1 = Fibonacci; sampled on load only.
LEN_I  in  $clog2(MAX_LEN+1)  active length L; sampled on load only.
SEED_I  in  MAX_LEN  initial state.
POLY_I  in  MAX_LEN  tap mask.
DATA_O  out  MAX_LEN  current state; bits above L are 0.
BIT_O  out  STEPS  serial output bits of the last advance; bit 0 is oldest.
VALID_O  out  1  one-cycle pulse: DATA_O and BIT_O were updated this cycle.
WRAP_O  out  1  one-cycle pulse: the state returned to the loaded seed during the last advance.
PERIOD_O  out  CNT_W  last measured period in steps.
PERIOD_VLD_O  out  1  PERIOD_O holds a valid measurement (sticky until the next load).
LOCKUP_O  out  1  state is all-zero; sticky until the next load.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, internal state/seed/poly/len/mode/counter all 0.
- Mask M = low L bits set. LEN_I values outside 2..MAX_LEN are clamped to MAX_LEN. Seed and poly are ANDed with M when latched.
- Galois step:
  - output bit b = s[0]
  - s' = s >> 1
  - if b = 1, then s' ^= poly
- Fibonacci step:
  - b = s[0]
  - fb = parity(s & poly)
  - s' = (s >> 1) with fb placed in bit L-1
- FSM states are IDLE, RUN, LOCKUP.
  - IDLE: ignores EN_I.
  - Any state, LOAD_I = 1: on the next edge, state := masked seed; counter := 0; PERIOD_VLD_O := 0; LOCKUP_O := 0. FSM goes to LOCKUP if the masked seed is 0, else to RUN.
  - LOAD_I has priority over a simultaneous EN_I.
  - The load edge itself does not assert VALID_O.
- RUN with EN_I = 1 (and no LOAD_I):
  - Apply STEPS chained steps combinationally; the register updates at the edge.
  - BIT_O[k] = output bit of sub-step k.
  - VALID_O = 1 for the following cycle only.
  - Latency: DATA_O reflects the advance 1 clock after EN_I is sampled.
- RUN with EN_I = 0: the state holds and VALID_O = 0.
- Period measurement:
  - Find the first sub-step j (1..STEPS) whose result equals the latched seed.
  - If one exists: PERIOD_O := cnt + j; PERIOD_VLD_O := 1; WRAP_O pulses; cnt := STEPS - j.
  - If none: cnt += STEPS, saturating at all-ones. A saturated counter never sets PERIOD_VLD_O.
  - Later wraps overwrite PERIOD_O with the same value.
- Lock-up: if the register becomes 0 (only possible with a degenerate poly), FSM goes to LOCKUP and LOCKUP_O = 1. Advancing stops, VALID_O stays 0, and only LOAD_I exits LOCKUP.
- Reset mid-operation: immediate return to the reset values; a new LOAD_I is required.

Decomposition:
- Package lfsr_pkg holds:
  - typedef enum logic {GALOIS, FIBONACCI} lfsr_mode_t
  - typedef enum logic [1:0] {IDLE, RUN, LOCKUP} lfsr_state_t
  - function len_mask(len) returning MAX_LEN-bit M
- Sub-module lfsr_step: combinational single step (state, poly, mask, mode -> next, bit). Instantiated STEPS times in a generate chain inside lfsr_multi.

Test Plan:
1. MAX_LEN=8, STEPS=1, L=4, Galois, poly=4'b1100, seed=4'b0001, EN=1 -> DATA sequence 1100, 0110, 0011, 1101, ... returns to 0001 after 15 steps; WRAP_O pulses; PERIOD_O=15; PERIOD_VLD_O=1; DATA_O[7:4]=0 throughout.
2. Same, Fibonacci, poly=4'b0011, seed=4'b0001 -> 1000, 0100, 0010, 1001, 1100, ... PERIOD_O=15.
3. STEPS=2, scenario 1 settings -> first VALID: DATA_O=4'b0110, BIT_O=2'b01; after 8 advances WRAP_O pulses with PERIOD_O=15 (wrap at sub-step 1).
4. Load seed=0 -> LOCKUP_O=1 on the next cycle, EN_I ignored, VALID_O=0; then load seed=4'b0001 -> LOCKUP_O=0, RUN resumes.
5. LOAD_I and EN_I high in the same cycle mid-run -> DATA_O = new seed, no VALID_O, counter restarts, PERIOD_VLD_O cleared.
6. RST_N_I pulsed low mid-run, asynchronous to the clock -> all outputs 0 immediately; EN_I ignored until the next LOAD_I.
